// File: rtl/ref_model_sched_pkg.sv
// Shared types for the retirement scheduler: RVFI record layout and scheduler state.
package ref_model_sched_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [63:0]     order;
        logic [XLEN-1:0] pc_rdata;
        logic [31:0]     insn;
        logic            trap;
        logic            halt;
        logic            intr;
    } rvfi_slot_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } sched_state_e;

endpackage

// File: rtl/ref_model_sched_fifo.sv
// Multi-write (lane-compacted), single-read circular buffer; read data is registered storage, no bypass.
// Caller gates wr_en/rd_en; clear has priority and empties the buffer.
module ref_model_sched_fifo
    import ref_model_sched_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear,
    input  logic                           wr_en,
    input  logic [NRET-1:0]                wr_valid,
    input  rvfi_slot_t [NRET-1:0]          wr_data,
    input  logic                           rd_en,
    output rvfi_slot_t                     rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    rvfi_slot_t      mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   lane_off [NRET];
    logic [CW-1:0]   n_wr;

    // Each valid lane lands at wptr + (number of valid lanes below it), so holes never appear.
    always_comb begin
        n_wr = '0;
        for (int i = 0; i < NRET; i++) begin
            lane_off[i] = n_wr[PW-1:0];
            n_wr        = n_wr + CW'(wr_valid[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < NRET; i++) begin
                if (wr_valid[i]) begin
                    mem[wptr + lane_off[i]] <= wr_data[i];
                end
            end
        end
    end

    assign rd_data = mem[rptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + n_wr[PW-1:0];
            end
            if (rd_en) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + (wr_en ? n_wr : CW'(0)) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/ref_model_retire_sched.sv
// Retirement scheduler: buffers up to NRET RVFI records/cycle, dispatches one/cycle (valid/ready), stops after halt.
// Optional order checker enabled by REF_MODEL_ORDER_CHECK_EN; overflow/order flags are sticky until flush/reset.
module ref_model_retire_sched
    import ref_model_sched_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NRET-1:0]                in_valid_i,
    input  rvfi_slot_t [NRET-1:0]          in_slot_i,
    output logic                           in_ready_o,
    output logic                           out_valid_o,
    output rvfi_slot_t                     out_slot_o,
    input  logic                           out_ready_i,
    input  logic                           flush_i,
    output logic                           halted_o,
    output logic                           overflow_o,
    output logic                           order_err_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int CW = $clog2(DEPTH+1);

    if (XLEN != ref_model_sched_pkg::XLEN) begin : g_xlen_mismatch
        $error("XLEN must match ref_model_sched_pkg::XLEN");
    end

    sched_state_e  state;
    logic [CW-1:0] count;
    logic          any_in;
    logic          enq;
    logic          drop;
    logic          deq;

    assign any_in      = |in_valid_i;
    // Based on registered count only: a dequeue this cycle does not open room until next cycle.
    assign in_ready_o  = count <= CW'(DEPTH - NRET);
    assign enq         = in_ready_o & any_in & ~flush_i;
    assign drop        = ~in_ready_o & any_in & ~flush_i;
    assign out_valid_o = (state == RUN) && (count != '0);
    assign deq         = out_valid_o & out_ready_i & ~flush_i;
    assign count_o     = count;

    ref_model_sched_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (flush_i),
        .wr_en    (enq),
        .wr_valid (in_valid_i),
        .wr_data  (in_slot_i),
        .rd_en    (deq),
        .rd_data  (out_slot_o),
        .count    (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= RUN;
            halted_o   <= 1'b0;
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            state      <= RUN;
            halted_o   <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (drop) begin
                overflow_o <= 1'b1;
            end
            if (state == RUN && deq && out_slot_o.halt) begin
                state    <= HALTED;
                halted_o <= 1'b1;
            end
        end
    end

`ifdef REF_MODEL_ORDER_CHECK_EN
    logic [63:0] last_order;
    logic [63:0] last_nxt;
    logic        have_last;
    logic        have_nxt;
    logic        err_hit;

    // Walk accepted lanes in order so later lanes compare against earlier ones in the same cycle.
    always_comb begin
        last_nxt = last_order;
        have_nxt = have_last;
        err_hit  = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (enq && in_valid_i[i]) begin
                if (have_nxt && (in_slot_i[i].order != last_nxt + 64'd1)) begin
                    err_hit = 1'b1;
                end
                last_nxt = in_slot_i[i].order;
                have_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_order  <= '0;
            have_last   <= 1'b0;
            order_err_o <= 1'b0;
        end else if (flush_i) begin
            last_order  <= '0;
            have_last   <= 1'b0;
            order_err_o <= 1'b0;
        end else begin
            last_order <= last_nxt;
            have_last  <= have_nxt;
            if (err_hit) begin
                order_err_o <= 1'b1;
            end
        end
    end
`else
    assign order_err_o = 1'b0;
`endif

endmodule
